// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester (I) and a
// load/store requester (D). Each transaction runs IDLE -> ACCESS -> RESP,
// spending WAIT_CYCLES cycles in ACCESS to model slow memory. D has fixed
// priority over I, and a starvation counter hands the port to I after
// STARVE_LIMIT consecutive D grants made while I was waiting.
//
// Handshake (both requesters): the requester raises req and holds it until
// its ready pulses. Address, data, we and size are latched at the grant, so
// later changes are ignored. Dropping req after the grant does not cancel
// the access; ready still pulses exactly once, in the single RESP cycle.
// A req still high in the IDLE cycle after RESP counts as a new request.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WCW-1:0]   wcnt;
    logic [SCW-1:0]   starve_cnt;
    logic             owner_d;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic             lat_we;
    logic [1:0]       lat_size;

    logic             starved;
    logic             grant_d;
    logic             grant_i;
    logic             last_access;

    // I is only forced through once D has won STARVE_LIMIT times in a row
    // while I was waiting.
    assign starved     = (starve_cnt == SCW'(STARVE_LIMIT));
    assign grant_d     = (state == S_IDLE) && d_req && !(i_req && starved);
    assign grant_i     = (state == S_IDLE) && i_req && !grant_d;
    assign last_access = (state == S_ACCESS) && (wcnt == '0);

    // State register; async reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the IDLE -> ACCESS -> RESP loop.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (i_req || d_req) state_next = S_ACCESS;
            S_ACCESS: if (wcnt == '0)     state_next = S_RESP;
            S_RESP:                       state_next = S_IDLE;
            default:                      state_next = S_IDLE;
        endcase
    end

    // Latch the winner's request at grant and count down the wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            wcnt      <= '0;
        end else if (grant_d) begin
            owner_d   <= 1'b1;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_we    <= d_we;
            lat_size  <= d_size;
            wcnt      <= WCW'(WAIT_CYCLES - 1);
        end else if (grant_i) begin
            owner_d   <= 1'b0;
            lat_addr  <= i_addr;
            lat_we    <= 1'b0;
            lat_size  <= 2'd3;
            wcnt      <= WCW'(WAIT_CYCLES - 1);
        end else if (state == S_ACCESS && wcnt != '0) begin
            wcnt      <= wcnt - 1'b1;
        end
    end

    // Starvation counter: grows on D grants while I waits, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!i_req) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Capture read data in the last ACCESS cycle; for a store this is the
    // value the memory held before the write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (last_access) begin
            if (owner_d) begin
                d_rdata <= mem_rdata;
            end else begin
                i_rdata <= mem_rdata;
            end
        end
    end

    // Write enable only in the final ACCESS cycle, so memory sees one write
    // edge; it falls with the async reset because state clears at once.
    assign mem_we    = last_access && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_size  = lat_size;
    assign i_ready   = (state == S_RESP) && !owner_d;
    assign d_ready   = (state == S_RESP) && owner_d;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
